// File: rtl/codeword_assembler_if.sv
// rtl/codeword_assembler_if.sv - byte-in / coded-word-out bus of the codeword assembler
interface codeword_assembler_if #(
  parameter int NBYTES = 4
);
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_err;
  logic [8*NBYTES-1:0] cw_data;
  logic                cw_valid;
  logic                cw_ready;
  logic [CNT_W-1:0]    byte_cnt;
  logic                overflow;
  logic                timeout_evt;

  modport master (
    output rx_data, rx_valid, rx_err, cw_ready,
    input  cw_data, cw_valid, byte_cnt, overflow, timeout_evt
  );

  modport slave (
    input  rx_data, rx_valid, rx_err, cw_ready,
    output cw_data, cw_valid, byte_cnt, overflow, timeout_evt
  );
endinterface

// File: rtl/codeword_assembler.sv
// rtl/codeword_assembler.sv - packs NBYTES received bytes into one coded word, first byte in MSBs
// Optional inter-byte timeout is enabled by defining ASM_TIMEOUT_EN.
module codeword_assembler #(
  parameter int NBYTES      = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst,
  codeword_assembler_if.slave bus
);
  localparam int CW_W  = 8 * NBYTES;
  localparam int ASM_W = 8 * (NBYTES - 1);
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Only the first NBYTES-1 bytes need storing; the final byte completes the word directly.
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW_W-1:0]  cw_data_q, cw_data_d;
  logic             cw_valid_q, cw_valid_d;
  logic             overflow_q, overflow_d;
  logic             accept, last, out_free;
  logic [CW_W-1:0]  word;

  assign accept   = bus.rx_valid && !bus.rx_err;
  assign last     = accept && (cnt_q == CNT_W'(NBYTES - 1));
  assign word     = {asm_q, bus.rx_data};
  assign out_free = !cw_valid_q || bus.cw_ready;

`ifdef ASM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_evt_q, tmo_evt_d;
`endif

  always_comb begin
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    cw_data_d  = cw_data_q;
    cw_valid_d = cw_valid_q && !bus.cw_ready;
    overflow_d = 1'b0;
    if (bus.rx_err) begin
      cnt_d = '0;
    end else if (accept) begin
      asm_d = word[ASM_W-1:0];
      if (last) begin
        cnt_d = '0;
        if (out_free) begin
          cw_data_d  = word;
          cw_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`ifdef ASM_TIMEOUT_EN
    tmo_d     = '0;
    tmo_evt_d = 1'b0;
    // Counter only advances on idle cycles inside a partial word; bytes and errors restart it.
    if (!bus.rx_err && !accept && cnt_q != '0) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        cnt_d     = '0;
        tmo_evt_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      cw_data_q  <= '0;
      cw_valid_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef ASM_TIMEOUT_EN
      tmo_q      <= '0;
      tmo_evt_q  <= 1'b0;
`endif
    end else begin
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      cw_data_q  <= cw_data_d;
      cw_valid_q <= cw_valid_d;
      overflow_q <= overflow_d;
`ifdef ASM_TIMEOUT_EN
      tmo_q      <= tmo_d;
      tmo_evt_q  <= tmo_evt_d;
`endif
    end
  end

  assign bus.cw_data  = cw_data_q;
  assign bus.cw_valid = cw_valid_q;
  assign bus.byte_cnt = cnt_q;
  assign bus.overflow = overflow_q;

`ifdef ASM_TIMEOUT_EN
  assign bus.timeout_evt = tmo_evt_q;
`else
  // Never fires here; TIMEOUT_CYC is referenced so both builds keep one parameter list.
  assign bus.timeout_evt = 1'b0 && (TIMEOUT_CYC != 0);
`endif
endmodule

// File: tb/tb_codeword_assembler.sv
// tb/tb_codeword_assembler.sv - directed vector bench for codeword_assembler (honours ASM_TIMEOUT_EN)
module tb_codeword_assembler;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  codeword_assembler_if #(.NBYTES(4)) bus ();

  codeword_assembler #(.NBYTES(4), .TIMEOUT_CYC(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        e;
    logic        r;
    logic [31:0] x_data;
    logic        x_vld;
    logic [1:0]  x_cnt;
    logic        x_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] d, input logic v, input logic e, input logic r,
                              input logic [31:0] xd, input logic xv, input logic [1:0] xc,
                              input logic xo);
    vec_t t;
    t.d = d; t.v = v; t.e = e; t.r = r;
    t.x_data = xd; t.x_vld = xv; t.x_cnt = xc; t.x_ov = xo;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic e, input logic r);
    bus.rx_data  = d;
    bus.rx_valid = v;
    bus.rx_err   = e;
    bus.cw_ready = r;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    step(d, 1'b1, 1'b0, r);
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    bus.cw_ready = 1'b0;

    // Basic word, overflow hold, same-cycle consume+load, error discard
    add(8'h36,1,0,1, 32'h00000000,0,2'd1,0);
    add(8'hE3,1,0,1, 32'h00000000,0,2'd2,0);
    add(8'h5B,1,0,1, 32'h00000000,0,2'd3,0);
    add(8'h8E,1,0,1, 32'h36E35B8E,1,2'd0,0);
    add(8'h00,0,0,1, 32'h36E35B8E,0,2'd0,0);
    add(8'h01,1,0,0, 32'h36E35B8E,0,2'd1,0);
    add(8'h02,1,0,0, 32'h36E35B8E,0,2'd2,0);
    add(8'h03,1,0,0, 32'h36E35B8E,0,2'd3,0);
    add(8'h04,1,0,0, 32'h01020304,1,2'd0,0);
    add(8'hA1,1,0,0, 32'h01020304,1,2'd1,0);
    add(8'hB2,1,0,0, 32'h01020304,1,2'd2,0);
    add(8'hC3,1,0,0, 32'h01020304,1,2'd3,0);
    add(8'hD4,1,0,0, 32'h01020304,1,2'd0,1);
    add(8'h00,0,0,0, 32'h01020304,1,2'd0,0);
    add(8'h5A,1,0,0, 32'h01020304,1,2'd1,0);
    add(8'h6B,1,0,0, 32'h01020304,1,2'd2,0);
    add(8'h7C,1,0,0, 32'h01020304,1,2'd3,0);
    add(8'h8D,1,0,1, 32'h5A6B7C8D,1,2'd0,0);
    add(8'h00,0,0,1, 32'h5A6B7C8D,0,2'd0,0);
    add(8'h11,1,0,1, 32'h5A6B7C8D,0,2'd1,0);
    add(8'h22,1,0,1, 32'h5A6B7C8D,0,2'd2,0);
    add(8'h00,0,1,1, 32'h5A6B7C8D,0,2'd0,0);
    add(8'h36,1,0,1, 32'h5A6B7C8D,0,2'd1,0);
    add(8'hE3,1,0,1, 32'h5A6B7C8D,0,2'd2,0);
    add(8'h5B,1,0,1, 32'h5A6B7C8D,0,2'd3,0);
    add(8'h8E,1,0,1, 32'h36E35B8E,1,2'd0,0);
    add(8'h00,0,0,1, 32'h36E35B8E,0,2'd0,0);
    add(8'hAA,1,0,1, 32'h36E35B8E,0,2'd1,0);
    add(8'hBB,1,1,1, 32'h36E35B8E,0,2'd0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset cw_data", bus.cw_data, 32'h0);
    chk("reset cw_valid", 32'(bus.cw_valid), 32'h0);
    chk("reset byte_cnt", 32'(bus.byte_cnt), 32'h0);
    chk("reset overflow", 32'(bus.overflow), 32'h0);
    chk("reset timeout_evt", 32'(bus.timeout_evt), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].d, vecs[i].v, vecs[i].e, vecs[i].r);
      chk($sformatf("row%0d cw_data", i), bus.cw_data, vecs[i].x_data);
      chk($sformatf("row%0d cw_valid", i), 32'(bus.cw_valid), 32'(vecs[i].x_vld));
      chk($sformatf("row%0d byte_cnt", i), 32'(bus.byte_cnt), 32'(vecs[i].x_cnt));
      chk($sformatf("row%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].x_ov));
      chk($sformatf("row%0d timeout_evt", i), 32'(bus.timeout_evt), 32'h0);
    end

`ifdef ASM_TIMEOUT_EN
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    for (int k = 1; k < 20; k++) begin
      step(8'h00, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tmo idle%0d timeout_evt", k), 32'(bus.timeout_evt), 32'h0);
    end
    chk("tmo pre-expiry byte_cnt", 32'(bus.byte_cnt), 32'd2);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("tmo expiry timeout_evt", 32'(bus.timeout_evt), 32'h1);
    chk("tmo expiry byte_cnt", 32'(bus.byte_cnt), 32'd0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("tmo pulse width", 32'(bus.timeout_evt), 32'h0);

    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    repeat (19) step(8'h00, 1'b0, 1'b0, 1'b1);
    send(8'h05, 1'b1);
    chk("tmo byte-wins timeout_evt", 32'(bus.timeout_evt), 32'h0);
    chk("tmo byte-wins byte_cnt", 32'(bus.byte_cnt), 32'd3);
    for (int k = 1; k < 20; k++) begin
      step(8'h00, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tmo restart idle%0d timeout_evt", k), 32'(bus.timeout_evt), 32'h0);
    end
    chk("tmo restart byte_cnt", 32'(bus.byte_cnt), 32'd3);
    send(8'h06, 1'b1);
    chk("tmo word cw_data", bus.cw_data, 32'h03040506);
    chk("tmo word cw_valid", 32'(bus.cw_valid), 32'h1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
`else
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      step(8'h00, 1'b0, 1'b0, 1'b1);
      chk($sformatf("no-tmo idle%0d timeout_evt", k), 32'(bus.timeout_evt), 32'h0);
    end
    chk("no-tmo byte_cnt held", 32'(bus.byte_cnt), 32'd2);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    chk("no-tmo word cw_data", bus.cw_data, 32'h01020304);
    chk("no-tmo word cw_valid", 32'(bus.cw_valid), 32'h1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
`endif

    // Asynchronous reset with a pending word and a partial word
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    chk("pre-rst cw_valid", 32'(bus.cw_valid), 32'h1);
    chk("pre-rst byte_cnt", 32'(bus.byte_cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async rst cw_data", bus.cw_data, 32'h0);
    chk("async rst cw_valid", 32'(bus.cw_valid), 32'h0);
    chk("async rst byte_cnt", 32'(bus.byte_cnt), 32'h0);
    chk("async rst overflow", 32'(bus.overflow), 32'h0);
    chk("async rst timeout_evt", 32'(bus.timeout_evt), 32'h0);
    #2 rst = 1'b0;
    send(8'h36, 1'b1);
    send(8'hE3, 1'b1);
    send(8'h5B, 1'b1);
    chk("post-rst byte_cnt", 32'(bus.byte_cnt), 32'd3);
    send(8'h8E, 1'b1);
    chk("post-rst cw_data", bus.cw_data, 32'h36E35B8E);
    chk("post-rst cw_valid", 32'(bus.cw_valid), 32'h1);
    chk("post-rst overflow", 32'(bus.overflow), 32'h0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("post-rst consumed", 32'(bus.cw_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
